// File: rtl/peak_event_extractor.sv
// Groups runs of detector-flagged samples into peak events (start, max, max index, width)
// and queues accepted events in a small first-word-fall-through FIFO with valid/ready output.
module peak_event_extractor #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  peak_in,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic [3:0]            merge_gap,
  input  logic [7:0]            min_width,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [IDX_WIDTH-1:0]  evt_start_idx,
  output logic [IDX_WIDTH-1:0]  evt_peak_idx,
  output logic [DATA_WIDTH-1:0] evt_peak_value,
  output logic [7:0]            evt_width,
  output logic                  overflow,
  output logic [7:0]            drop_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, IN_PEAK, GAP} state_t;

  typedef struct packed {
    logic [IDX_WIDTH-1:0]  start_idx;
    logic [IDX_WIDTH-1:0]  peak_idx;
    logic [DATA_WIDTH-1:0] peak_value;
    logic [7:0]            width;
  } event_t;

  state_t               state, state_nx;
  logic [IDX_WIDTH-1:0] idx;
  event_t               cur, cur_nx, upd;
  logic [3:0]           gap_cnt, gap_nx;
  logic                 close_evt;
  logic                 accept;
  logic [IDX_WIDTH-1:0] span;

  event_t               pend;
  logic                 pend_valid;

  event_t               mem [FIFO_DEPTH];
  logic [PTR_W:0]       wr_ptr, rd_ptr;
  logic                 full;
  logic                 do_push, do_pop, drop;
  event_t               head;

  // Current event extended by a flagged sample at idx; width saturates and stays saturated.
  assign span = idx - cur.start_idx;

  always_comb begin
    upd = cur;
    if (cur.width == 8'hFF || span >= IDX_WIDTH'(255)) upd.width = 8'hFF;
    else                                                upd.width = span[7:0] + 8'd1;
    if ($signed(sample_in) > $signed(cur.peak_value)) begin
      upd.peak_value = sample_in;
      upd.peak_idx   = idx;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx  = state;
    cur_nx    = cur;
    gap_nx    = gap_cnt;
    close_evt = 1'b0;
    if (en) begin
      unique case (state)
        IDLE: begin
          if (peak_in) begin
            cur_nx   = '{start_idx: idx, peak_idx: idx, peak_value: sample_in, width: 8'd1};
            state_nx = IN_PEAK;
          end
        end
        IN_PEAK: begin
          if (peak_in) begin
            cur_nx = upd;
          end else if (merge_gap == 4'd0) begin
            close_evt = 1'b1;
            state_nx  = IDLE;
          end else begin
            gap_nx   = 4'd1;
            state_nx = GAP;
          end
        end
        GAP: begin
          if (peak_in) begin
            cur_nx   = upd;
            state_nx = IN_PEAK;
          end else begin
            gap_nx = gap_cnt + 4'd1;
            if (gap_nx >= merge_gap) begin
              close_evt = 1'b1;
              state_nx  = IDLE;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign accept = close_evt && (cur.width >= min_width);

  // NOTE: sequential state is assigned with <= so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= '0;
      cur        <= '0;
      gap_cnt    <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
    end else begin
      state      <= state_nx;
      cur        <= cur_nx;
      gap_cnt    <= gap_nx;
      pend_valid <= accept;
      if (accept) pend <= cur;
      if (en)     idx  <= idx + 1'b1;
    end
  end

  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_pop  = evt_valid && evt_ready;
  assign do_push = pend_valid && (!full || do_pop);
  assign drop    = pend_valid && full && !do_pop;

  // NOTE: the storage array has no reset; outputs are masked by evt_valid, so stale entries never show.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= pend;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
    end
  end

  assign evt_valid      = (wr_ptr != rd_ptr);
  assign head           = mem[rd_ptr[PTR_W-1:0]];
  assign evt_start_idx  = evt_valid ? head.start_idx  : '0;
  assign evt_peak_idx   = evt_valid ? head.peak_idx   : '0;
  assign evt_peak_value = evt_valid ? head.peak_value : '0;
  assign evt_width      = evt_valid ? head.width      : '0;

endmodule

// File: doc/peak_event_extractor.md
Name: peak_event_extractor

Overview:
- Sits directly downstream of peak_detection.
- Consumes its per-sample peak flag and filtered sample stream, and groups runs of flagged samples into discrete peak events.
- Nearby runs are merged, short runs are rejected, and each accepted event's start index, maximum value, index of maximum and width are queued.
- Events leave through a small FIFO with a valid/ready handshake toward the host/logging side.

Parameters:
DATA_WIDTH, 16, sample width (signed Q8.8)
IDX_WIDTH, 16, sample index counter width (wraps modulo 2^IDX_WIDTH)
FIFO_DEPTH, 4, event FIFO depth (power of two, >=2)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset
en  in  1  sample strobe, aligned with peak_in/sample_in (same strobe that drives the detector)
peak_in  in  1  detector peak_status for this sample
sample_in  in  DATA_WIDTH  signed sample paired with peak_in
merge_gap  in  4  non-peak samples that end an event (0 = end on first non-peak)
min_width  in  8  minimum event width to accept; 0 and 1 accept all
evt_valid  out  1  FIFO non-empty
evt_ready  in  1  consumer accepts head event when evt_valid & evt_ready
evt_start_idx  out  IDX_WIDTH  index of first flagged sample of event
evt_peak_idx  out  IDX_WIDTH  index of maximum flagged sample
evt_peak_value  out  DATA_WIDTH  maximum flagged sample value (signed)
evt_width  out  8  last_flagged_idx - start_idx + 1, saturating at 255
overflow  out  1  sticky: an accepted event was dropped because the FIFO was full
drop_count  out  8  count of FIFO-full drops, saturating at 255

Behaviour:
- Reset (rst=0, async):
  - FSM returns to IDLE; sample index, FIFO pointers, overflow and drop_count are cleared.
  - evt_valid=0 and all evt_* outputs are 0.
  - Any event in progress is discarded.
- Sample index: the first en after reset is index 0, and the index increments on every en. It wraps without a flag.
- When en=0, the FSM, counters and index hold. FIFO pops still occur.
- FSM states:
  - IDLE: on en&peak_in, capture start=max_idx=idx, max=sample_in, width=1 -> IN_PEAK.
  - IN_PEAK, en&peak_in:
    - width=idx-start+1.
    - If sample_in > max (signed, strict), update max and max_idx. Ties keep the earliest index.
  - IN_PEAK, en&!peak_in: if merge_gap==0, close the event -> IDLE; otherwise gap_cnt=1 -> GAP.
  - GAP, en&!peak_in: gap_cnt+1. When the new count equals merge_gap, close the event -> IDLE.
  - GAP, en&peak_in: merge into the current event (same update as IN_PEAK) -> IN_PEAK. Gap samples never contribute to the max.
- Close:
  - If width >= min_width, the event is pushed; otherwise it is silently discarded (no counter change).
  - Closing sample accepted at edge k -> event written into the pipeline register -> FIFO write at edge k+1.
  - With an empty FIFO, evt_valid=1 and fields are valid after edge k+1 (1-cycle latency).
- Width saturates at 255 while the event continues; index and max tracking continue normally.
- merge_gap and min_width are sampled live and must only change while IDLE. Behaviour on a change mid-event is undefined.
- FIFO:
  - First-word fall-through; evt_* fields show the head entry.
  - A pop occurs on evt_valid&evt_ready.
  - A push while full with no pop in the same cycle drops the new event, sets overflow and increments drop_count (saturating).
  - A push and pop in the same cycle while full succeeds with no drop.
  - A push and pop in the same cycle while empty: the push lands and evt_valid=1 next cycle.
- overflow clears only on reset.

Test Plan:
- merge_gap=2, min_width=2, en every cycle. Peaks at idx 2,3,4 with values 100,300,200, then non-peak samples.
  -> One event: start=2, peak_idx=3, value=300, width=3.
  -> evt_valid rises one cycle after the idx-6 edge.
- merge_gap=2. Peaks at 10,11, non-peak at 12, peak at 13 (values 5,7,99(gap),6).
  -> One event: start=10, width=4, peak value=7, peak_idx=11 (gap sample ignored).
- min_width=2. Single isolated peak at idx 20 -> no event and drop_count=0.
- Same isolated peak with min_width=1 -> event start=20, width=1.
- Signed and tie handling: peak values -5,-3,-3 at idx 30..32 -> value=-3 (0xFFFD), peak_idx=31.
- evt_ready=0 with 5 accepted events -> 4 queued, overflow=1, drop_count=1.
  -> After raising evt_ready, 4 events drain in order over 4 cycles, then evt_valid=0.
- Assert rst low for 1 cycle mid-event (IN_PEAK, FIFO holding 2 events).
  -> evt_valid=0 immediately, overflow=0, next en gets index 0, no partial event is emitted.
- en gaps: en low for 3 cycles between peak samples 40 and 41 with merge_gap=0.
  -> Still one event, width=2 (en-low cycles are not samples).
